mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage alongside the ALU and consuming the same forwarded operand pair (In1 = rs, In2 = rt). It models MIPS mult/div latency with a cycle counter and drives a busy flag that the hazard unit uses to stall any md-class instruction in ID. Results become architecturally visible in HI/LO, which mfhi/mflo read through the normal EX result path.

---
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle mult/div unit with HI/LO; MDU_MADD_EN enables madd/maddu/msub/msubu
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic [3:0]  MDop,
  input  logic        start,
  output logic        busy,
  output logic        md_pending,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul_class;
  logic        is_div_class;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] result;

  // Classify the incoming op: which encodings launch a timed operation.
  always_comb begin
    is_mul_class = (MDop == OP_MULT) || (MDop == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul_class = is_mul_class || (MDop == OP_MADD) || (MDop == OP_MADDU) ||
                   (MDop == OP_MSUB) || (MDop == OP_MSUBU);
`endif
    is_div_class = (MDop == OP_DIV) || (MDop == OP_DIVU);
  end

  // HI/LO value to commit when the in-flight op finishes, from the latched operands.
  always_comb begin
    prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u     = {32'b0, a_q} * {32'b0, b_q};
    signed_div = (op_q == OP_DIV);
    abs_a      = (signed_div && a_q[31]) ? -a_q : a_q;
    abs_b      = (signed_div && b_q[31]) ? -b_q : b_q;
    // Divide-by-zero commits nothing; steer the divider to a harmless divisor.
    div_b      = (abs_b == 32'd0) ? 32'd1 : abs_b;
    quo_u      = abs_a / div_b;
    rem_u      = abs_a % div_b;
    // 0x80000000 / -1 falls out naturally: the magnitude wraps back to 0x80000000.
    quo        = (signed_div && (a_q[31] ^ b_q[31])) ? -quo_u : quo_u;
    rem        = (signed_div && a_q[31]) ? -rem_u : rem_u;
    result     = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q != 32'd0) result = {rem, quo};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MADDU: result = {hi_q, lo_q} + prod_u;
      OP_MSUB:  result = {hi_q, lo_q} - prod_s;
      OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
      default: result = {hi_q, lo_q};
    endcase
  end

  // Control: accept ops only in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul_class || is_div_class) begin
            op_d    = MDop;
            a_d     = In1;
            b_d     = In2;
            cnt_d   = is_div_class ? DIV_CNT : MULT_CNT;
            state_d = RUN;
          end else if (MDop == OP_MTHI) begin
            hi_d = In1;
          end else if (MDop == OP_MTLO) begin
            lo_d = In1;
          end
        end
      end
      default: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d        = 4'd0;
          state_d      = IDLE;
          {hi_d, lo_d} = result;
        end
      end
    endcase
  end

  // State registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign md_pending = start | busy;
  assign HI         = hi_q;
  assign LO         = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [3:0]  MDop;
  logic        start;
  logic        busy;
  logic        md_pending;
  logic [31:0] HI;
  logic [31:0] LO;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .In1        (In1),
    .In2        (In2),
    .MDop       (MDop),
    .start      (start),
    .busy       (busy),
    .md_pending (md_pending),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted op on the model HI/LO, plus its busy length.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint      sa, sb, sq, sr;
    logic [63:0] ps, pu, acc, vq, vr;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = 64'(sa * sb);
    pu  = 64'(a) * 64'(b);
    acc = {m_hi, m_lo};
    lat = 0;
    case (op)
      4'd1: begin acc = ps; lat = MULT_LAT; end
      4'd2: begin acc = pu; lat = MULT_LAT; end
      4'd3: begin
        lat = DIV_LAT;
        if (b != 32'd0) begin
          sq = sa / sb;
          sr = sa % sb;
          vq = sq;
          vr = sr;
          acc = {vr[31:0], vq[31:0]};
        end
      end
      4'd4: begin
        lat = DIV_LAT;
        if (b != 32'd0) acc = {a % b, a / b};
      end
      4'd5: acc[63:32] = a;
      4'd6: acc[31:0]  = a;
`ifdef MDU_MADD_EN
      4'd7:  begin acc = acc + ps; lat = MULT_LAT; end
      4'd8:  begin acc = acc + pu; lat = MULT_LAT; end
      4'd9:  begin acc = acc - ps; lat = MULT_LAT; end
      4'd10: begin acc = acc - pu; lat = MULT_LAT; end
`endif
      default: lat = 0;
    endcase
    {m_hi, m_lo} = acc;
  endtask

  // Issue one op; b2b=1 issues on the current negedge (first idle cycle after a completion).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input bit poke);
    int lat;
    int n;
    model_op(op, a, b, lat);
    if (!b2b) @(negedge clk);
    MDop  = op;
    In1   = a;
    In2   = b;
    start = 1'b1;
    #1 check_val("md_pending_start", md_pending, 1);
    @(negedge clk);
    start = 1'b0;
    MDop  = 4'd0;
    n = 0;
    while (busy && n < 40) begin
      check_val("md_pending_busy", md_pending, 1);
      n++;
      In1 = $urandom;
      In2 = $urandom;
      if (poke && ($urandom_range(0, 2) == 0)) begin
        start = 1'b1;
        MDop  = 4'($urandom_range(1, 10));
      end
      @(negedge clk);
      start = 1'b0;
      MDop  = 4'd0;
    end
    check_val($sformatf("latency_op%0d", op), 64'(n), 64'(lat));
    check_val($sformatf("hi_op%0d", op), 64'(HI), 64'(m_hi));
    check_val($sformatf("lo_op%0d", op), 64'(LO), 64'(m_lo));
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;

    reset = 1'b1;
    start = 1'b0;
    MDop  = 4'd0;
    In1   = 32'd0;
    In2   = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_hi", 64'(HI), 0);
    check_val("rst_lo", 64'(LO), 0);
    check_val("rst_pending_idle", 64'(md_pending), 0);
    start = 1'b1;
    #1 check_val("rst_pending_start", 64'(md_pending), 1);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // directed cases
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    run_op(4'd5, 32'h00000011, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'h00000022, 32'd0, 1'b1, 1'b0);
    run_op(4'd4, 32'd7, 32'd0, 1'b0, 1'b1);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(4'd5, 32'h00001234, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'h00005678, 32'd0, 1'b1, 1'b0);
    run_op(4'd0, 32'hDEADBEEF, 32'd1, 1'b0, 1'b0);
    run_op(4'd15, 32'hDEADBEEF, 32'd1, 1'b0, 1'b0);

    // accumulate ops (undefined when the feature is built out)
    run_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    run_op(4'd7, 32'd1, 32'd1, 1'b0, 1'b0);
    run_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'd0, 32'd0, 1'b1, 1'b0);
    run_op(4'd10, 32'd1, 32'd1, 1'b0, 1'b0);

    // back-to-back mult then div
    run_op(4'd1, 32'd1000, 32'hFFFFFF00, 1'b0, 1'b0);
    run_op(4'd3, 32'd1000, 32'd7, 1'b1, 1'b0);

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
      run_op(op, a, b, ($urandom_range(0, 2) == 0), 1'b1);
    end

    // reset in the middle of a divide
    run_op(4'd5, 32'hAAAA0000, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'h0000BBBB, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    MDop  = 4'd3;
    In1   = 32'd100;
    In2   = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDop  = 4'd0;
    repeat (3) @(negedge clk);
    check_val("pre_rst_busy", 64'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_busy", 64'(busy), 0);
    check_val("mid_rst_hi", 64'(HI), 0);
    check_val("mid_rst_lo", 64'(LO), 0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (15) @(negedge clk);
    check_val("post_rst_busy", 64'(busy), 0);
    check_val("post_rst_hi", 64'(HI), 0);
    check_val("post_rst_lo", 64'(LO), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
